// File: rtl/sb_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sb_cfg_loader_if
// Description : Host configuration-word stream (valid/ready) feeding the
//               switch-box scan-chain loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface sb_cfg_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    // Host side: offers words
    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    // Loader side: accepts words
    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface
`default_nettype wire

// File: rtl/sb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : sb_cfg_loader
// Description : Serialises host configuration words MSB-first into the
//               switch-box scan chain, with an optional recirculating
//               readback pass that compares the number of 1 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_cfg_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 256
) (
    input  wire logic           clk,
    input  wire logic           nrst,
    input  wire logic           i_start,
    input  wire logic           i_verify_en,
    input  wire logic           i_abort,
    sb_cfg_loader_if.slave      host,
    output logic                o_cfg_en,
    output logic                o_cfg_step,
    output logic                o_cfg_data,
    input  wire logic           i_cfg_return,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WC_W  = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_SHIFT     = 3'd2,
        S_VERIFY    = 3'd3,
        S_FIN       = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_shreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_vcnt;
    logic [CNT_W-1:0]   r_ones_in;
    logic [CNT_W-1:0]   r_ones_ret;
    logic [WC_W-1:0]    r_wcnt;
    logic               r_verify;
    logic               r_error;
    logic [CNT_W-1:0]   w_remain;
    logic [WC_W-1:0]    w_wcnt_load;
    logic               w_abort;
    logic [CNT_W-1:0]   w_ones_ret_final;

    // Bits of the chain still to be written; the last word may be partial.
    assign w_remain    = CNT_W'(CHAIN_LEN) - r_bit_cnt;
    assign w_wcnt_load = (32'(w_remain) < 32'(WORD_W)) ? WC_W'(w_remain) : WC_W'(WORD_W);
    assign w_abort     = i_abort && (r_state != S_IDLE);
    // Readback count including the bit returning in the current cycle.
    assign w_ones_ret_final = r_ones_ret + CNT_W'(i_cfg_return);

    assign o_busy  = (r_state != S_IDLE);
    assign o_error = r_error;

    // State register; async reset so cfg_en drops the instant nrst asserts.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and chain/host strobes decoded from the current state.
    always_comb begin
        w_state_nxt     = r_state;
        o_cfg_en        = 1'b0;
        o_cfg_step      = 1'b0;
        o_cfg_data      = 1'b0;
        o_done          = 1'b0;
        host.word_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                o_cfg_en        = 1'b1;
                host.word_ready = 1'b1;
                if (host.word_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                o_cfg_en   = 1'b1;
                o_cfg_step = 1'b1;
                o_cfg_data = r_shreg[WORD_W-1];
                if (r_wcnt == WC_W'(1)) begin
                    if (r_bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                        w_state_nxt = r_verify ? S_VERIFY : S_FIN;
                    end else begin
                        w_state_nxt = S_WAIT_WORD;
                    end
                end
            end
            S_VERIFY: begin
                // Recirculate: whatever leaves the chain goes straight back in.
                o_cfg_en   = 1'b1;
                o_cfg_step = 1'b1;
                o_cfg_data = i_cfg_return;
                if (r_vcnt == CNT_W'(CHAIN_LEN - 1)) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: word capture, serialisation, bit/ones counting, error flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_vcnt     <= '0;
            r_ones_in  <= '0;
            r_ones_ret <= '0;
            r_wcnt     <= '0;
            r_verify   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_bit_cnt  <= '0;
                        r_vcnt     <= '0;
                        r_ones_in  <= '0;
                        r_ones_ret <= '0;
                        r_error    <= 1'b0;
                        r_verify   <= i_verify_en;
                    end
                end
                S_WAIT_WORD: begin
                    if (host.word_valid) begin
                        r_shreg <= host.word_data;
                        r_wcnt  <= w_wcnt_load;
                    end
                end
                S_SHIFT: begin
                    r_shreg   <= r_shreg << 1;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    r_wcnt    <= r_wcnt - WC_W'(1);
                    r_ones_in <= r_ones_in + CNT_W'(r_shreg[WORD_W-1]);
                end
                S_VERIFY: begin
                    r_vcnt     <= r_vcnt + CNT_W'(1);
                    r_ones_ret <= w_ones_ret_final;
                    // Judged on the edge into FIN so error is valid alongside done.
                    if ((r_vcnt == CNT_W'(CHAIN_LEN - 1)) && (w_ones_ret_final != r_ones_in)) begin
                        r_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (w_abort) begin
                r_error <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
